layer2_input_packer: RTL
========================

Name: layer2_input_packer

Overview:
- Upstream feeder for the layer-2 generator MAC engine.
- Accepts a serial stream of 16-bit Q8.8 activations over a valid/ready handshake and assembles them into an N-element flattened vector.
- Pulses `start` once per complete vector, then holds the vector bit-stable until the engine returns `layer_done`. The engine reads its input bus on every MAC cycle, so the vector must not change while it runs.
- Provides framing checks and a done-timeout watchdog.

Parameters:
- N, 256, elements per vector. Must be ≥ 2.
- DATA_W, 16, element width (signed Q8.8).
- APPLY_RELU, 0, when 1, negative elements are stored as 0 on capture.
- TIMEOUT_CYCLES, 70000, maximum cycles from `start` to `layer_done` before abort.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  packer can accept an element
- s_data  in  DATA_W  signed input element
- s_last  in  1  marks the final element of a vector
- flat_vec_out  out  DATA_W*N  flattened vector; element k at [DATA_W*k+DATA_W-1 : DATA_W*k]
- start  out  1  one-cycle launch pulse to the MAC engine
- layer_done  in  1  one-cycle completion pulse from the MAC engine
- busy  out  1  high in LAUNCH and WAIT_DONE
- frame_err  out  1  sticky framing error
- timeout_err  out  1  sticky watchdog error
- err_clear  in  1  clears both sticky errors
- vec_count  out  16  vectors launched, wraps at 2^16

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - state = FILL, idx = 0, s_ready = 1
  - flat_vec_out = 0, start = 0, busy = 0
  - frame_err = 0, timeout_err = 0, vec_count = 0, watchdog = 0
- Reset mid-operation: abandons any partial or running vector. A later `layer_done` is ignored.
- Handshake: an element is accepted on a cycle with s_valid && s_ready.
  - s_ready is a registered output and equals (state == FILL).
  - s_data and s_last are don't-care when s_valid = 0.
- Capture: the accepted element is written to slot idx. With APPLY_RELU = 1 and s_data < 0, the slot is written as 0.
- FILL state:
  - Accept at idx < N-1 with s_last = 0: write slot, idx++.
  - Accept at idx < N-1 with s_last = 1 (short frame): do not write the slot, set frame_err, idx <= 0, stay in FILL. Slots already written remain but are overwritten by the next frame.
  - Accept at idx = N-1: write slot, idx <= 0, go to LAUNCH. If s_last = 0 (long frame), also set frame_err. The vector is still launched, and subsequent elements start a new vector.
- LAUNCH state (exactly 1 cycle): start = 1, vec_count++, watchdog <= 0, go to WAIT_DONE.
- Launch latency: the last element is accepted in cycle t, start is high in t+1, s_ready is low from t+1.
- WAIT_DONE state: start = 0, watchdog++.
  - layer_done = 1: go to FILL; s_ready is high on the next cycle.
  - Otherwise, when watchdog reaches TIMEOUT_CYCLES-1: set timeout_err, go to FILL.
  - layer_done on that same cycle takes priority and no error is set.
- layer_done in FILL or LAUNCH is ignored.
- flat_vec_out changes only on FILL writes, so it is stable from LAUNCH through the exit from WAIT_DONE.
- err_clear: clears frame_err and timeout_err the next cycle. A set event on the same cycle wins.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES).

Decomposition:
- Package `gan_layer_pkg`: DATA_W = 16, LAYER2_N = 256, the packer state enum {FILL, LAUNCH, WAIT_DONE}, and the function elem_relu().
- No sub-module. Slot write, FSM and watchdog fit in one module.

Test Plan:
- N=4, stream 0x0100, 0xFF00, 0x0080, 0x7FFF with s_last on the 4th element → start pulses one cycle after the 4th accept; flat_vec_out = {7FFF, 0080, FF00, 0100}; vec_count = 1; s_ready = 0 until 1 cycle after layer_done.
- N=4, APPLY_RELU=1, same stream → flat_vec_out = {7FFF, 0080, 0000, 0100}.
- N=4, s_last on the 2nd element → frame_err = 1, no start; the next 4-element frame launches normally; err_clear then drops frame_err.
- N=4, hold s_valid high during WAIT_DONE with changing data → no accept, flat_vec_out unchanged until layer_done.
- N=4, TIMEOUT_CYCLES=10, never assert layer_done → timeout_err = 1 ten cycles after start, state returns to FILL. A repeat run with layer_done on the 10th cycle → no error.
- N=256 connected to the layer-2 generator, stream 256 elements of 0x0100 → exactly one start, engine done is received, s_ready re-asserts, vec_count = 1.

Source files
------------

// File: rtl/gan_layer_pkg.sv
// Shared types and constants for the GAN layer-2 datapath.
// The packer FSM encoding is exported here so checkers can decode the debug state.
package gan_layer_pkg;

  localparam int DATA_W   = 16;
  localparam int LAYER2_N = 256;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } packer_state_t;

  // Optional rectification applied as an element is captured into the vector.
  function automatic logic [DATA_W-1:0] elem_relu(input logic [DATA_W-1:0] x,
                                                  input logic enable);
    return (enable && x[DATA_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/layer2_input_packer.sv
// Collects a serial stream of Q8.8 activations into an N-element vector, launches the
// layer-2 MAC engine once per vector and holds the vector stable until the engine is done.
module layer2_input_packer #(
  parameter int N              = gan_layer_pkg::LAYER2_N,
  parameter int DATA_W         = gan_layer_pkg::DATA_W,
  parameter bit APPLY_RELU     = 1'b0,
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic [DATA_W*N-1:0]   flat_vec_out,
  output logic                  start,
  input  logic                  layer_done,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  timeout_err,
  input  logic                  err_clear,
  output logic [15:0]           vec_count,
  output logic [1:0]            dbg_state
);
  import gan_layer_pkg::*;

  // Handshake: an element transfers on any rising edge where s_valid && s_ready.
  // s_ready is registered and is high exactly while the FSM sits in FILL; s_data and
  // s_last are ignored whenever s_valid is low.

  localparam int IDX_W = $clog2(N);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  packer_state_t    state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [WD_W-1:0]  watchdog;
  logic             accept;
  logic             write_en;
  logic             frame_set;
  logic             timeout_set;

  assign accept    = s_valid && s_ready;
  assign dbg_state = state;

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    write_en    = 1'b0;
    frame_set   = 1'b0;
    timeout_set = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            // Vector is full: launch even if the sender did not mark the end.
            write_en   = 1'b1;
            idx_next   = '0;
            state_next = LAUNCH;
            frame_set  = !s_last;
          end else if (s_last) begin
            idx_next  = '0;
            frame_set = 1'b1;
          end else begin
            write_en = 1'b1;
            idx_next = idx + 1'b1;
          end
        end
      end
      LAUNCH: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (layer_done) begin
          state_next = FILL;
        end else if (watchdog == WD_LIMIT) begin
          timeout_set = 1'b1;
          state_next  = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      idx          <= '0;
      s_ready      <= 1'b1;
      start        <= 1'b0;
      busy         <= 1'b0;
      flat_vec_out <= '0;
      frame_err    <= 1'b0;
      timeout_err  <= 1'b0;
      vec_count    <= '0;
      watchdog     <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      s_ready <= (state_next == FILL);
      start   <= (state_next == LAUNCH);
      busy    <= (state_next != FILL);
      // The only writer of the vector, so it cannot move outside FILL.
      if (write_en)
        flat_vec_out[int'(idx)*DATA_W +: DATA_W] <= elem_relu(s_data, APPLY_RELU);
      if (state == LAUNCH) begin
        vec_count <= vec_count + 16'd1;
        watchdog  <= '0;
      end else if (state == WAIT_DONE) begin
        watchdog <= watchdog + 1'b1;
      end
      frame_err   <= frame_set   | (frame_err   & ~err_clear);
      timeout_err <= timeout_set | (timeout_err & ~err_clear);
    end
  end

endmodule
